// File: rtl/alfa_sequenciador_if.sv
// alfa_sequenciador_if
// Groups the score-write port, playback controls and decoder-facing outputs
// of the melody sequencer into one bundle.
//   master : the controller side (drives score writes and play/stop/loop/len,
//            observes the note outputs)
//   slave  : the sequencer itself
// AW is the score address width and must equal log2 of the sequencer depth.
interface alfa_sequenciador_if #(
    parameter int AW = 4
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [6:0]    wr_data;
    logic [AW-1:0] len;
    logic          loop;
    logic          play;
    logic          stop;
    logic          tom;
    logic [2:0]    notas;
    logic          note_on;
    logic [AW-1:0] step;
    logic          busy;
    logic          done;

    modport master (
        output wr_en, wr_addr, wr_data, len, loop, play, stop,
        input  tom, notas, note_on, step, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, len, loop, play, stop,
        output tom, notas, note_on, step, busy, done
    );
endinterface

// File: rtl/alfa_sequenciador.sv
// alfa_sequenciador
// Melody sequencer feeding the Alfa_xylo decoder. Holds an N_STEPS x 7 score
// (rest, tom, notas[2:0], dur[1:0]) and, after a play pulse, presents one
// step at a time on tom/notas, each lasting (dur+1)*TICKS_PER_BEAT cycles
// followed by GAP_TICKS silent cycles.
// Ports:
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of alfa_sequenciador_if
//              (wr_en/wr_addr/wr_data, len, loop, play, stop in;
//               tom, notas, note_on, step, busy, done out, all registered)
module alfa_sequenciador #(
    parameter int TICKS_PER_BEAT = 4,
    parameter int GAP_TICKS      = 1,
    parameter int N_STEPS        = 16
) (
    input logic             clock,
    input logic             reset_n,
    alfa_sequenciador_if.slave bus
);
    localparam int AW      = $clog2(N_STEPS);
    // One counter serves both PLAY (up to 4 beats) and GAP.
    localparam int CNT_MAX = (4 * TICKS_PER_BEAT > GAP_TICKS) ? 4 * TICKS_PER_BEAT : GAP_TICKS;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_PLAY = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [6:0]    mem [N_STEPS];
    logic [6:0]    entry;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] play_last;
    logic          end_of_step;
    logic [AW-1:0] len_q;
    logic [AW-1:0] step_q;
    logic [1:0]    dur_q;
    logic          tom_q;
    logic [2:0]    notas_q;
    logic          note_on_q;
    logic          busy_q;
    logic          done_q;

    // Score storage: plain synchronous-write RAM, never cleared, writable at
    // any time; the sequencer only looks at it during LOAD.
    always_ff @(posedge clock) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Last PLAY count of the current step and the point where the step's
    // fate (next/wrap/finish) is decided. With no gap the decision moves to
    // the final PLAY cycle.
    always_comb begin
        entry       = mem[step_q];
        play_last   = CW'((int'(dur_q) + 1) * TICKS_PER_BEAT - 1);
        end_of_step = 1'b0;
        if (state == S_PLAY && cnt == play_last && GAP_TICKS == 0) begin
            end_of_step = 1'b1;
        end
        if (state == S_GAP && cnt == GAP_LAST) begin
            end_of_step = 1'b1;
        end
    end

    // Sequencer FSM. stop is checked first so it beats both a start request
    // and an end-of-step decision in the same cycle. note_on is loaded from
    // the rest bit on the LOAD->PLAY edge, so it doubles as the registered
    // "not a rest" flag for the whole PLAY phase.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            len_q     <= '0;
            step_q    <= '0;
            dur_q     <= '0;
            tom_q     <= 1'b0;
            notas_q   <= '0;
            note_on_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.stop) begin
                state     <= S_IDLE;
                note_on_q <= 1'b0;
                busy_q    <= 1'b0;
            end else if (end_of_step) begin
                note_on_q <= 1'b0;
                if (step_q < len_q) begin
                    step_q <= step_q + AW'(1);
                    state  <= S_LOAD;
                end else if (bus.loop) begin
                    step_q <= '0;
                    state  <= S_LOAD;
                end else begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.play) begin
                            len_q  <= bus.len;
                            step_q <= '0;
                            busy_q <= 1'b1;
                            state  <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        tom_q     <= entry[5];
                        notas_q   <= entry[4:2];
                        dur_q     <= entry[1:0];
                        note_on_q <= ~entry[6];
                        cnt       <= '0;
                        state     <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (cnt == play_last) begin
                            cnt       <= '0;
                            note_on_q <= 1'b0;
                            state     <= S_GAP;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_GAP: begin
                        cnt <= cnt + CW'(1);
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.tom     = tom_q;
    assign bus.notas   = notas_q;
    assign bus.note_on = note_on_q;
    assign bus.step    = step_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_alfa_sequenciador.sv
// tb_alfa_sequenciador
// Scoreboard bench for alfa_sequenciador. Each playback request is turned by
// a step-list model into the expected sequence of events (sounding notes with
// their start offset and width, then a done or an abort), and a monitor
// rebuilds the same events from the DUT outputs and compares them in order.
module tb_alfa_sequenciador;
    localparam int TPB = 4;
    localparam int GAP = 1;
    localparam int NS  = 16;
    localparam int AW  = 4;

    localparam int K_NOTE  = 0;
    localparam int K_DONE  = 1;
    localparam int K_ABORT = 2;

    typedef struct {
        int kind;
        int step;
        int tom;
        int notas;
        int start;
        int width;
    } rec_t;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    alfa_sequenciador_if #(.AW(AW)) bus ();

    alfa_sequenciador #(
        .TICKS_PER_BEAT (TPB),
        .GAP_TICKS      (GAP),
        .N_STEPS        (NS)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [6:0] score [NS];
    rec_t       exp_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    // Direct comparison of one value.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Compare an observed event against the oldest expected one.
    task automatic emit(input rec_t got);
        rec_t want;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("[TB] FAIL unexpected_event: got kind=%0d step=%0d tom=%0d notas=%0d start=%0d width=%0d, expected none",
                     got.kind, got.step, got.tom, got.notas, got.start, got.width);
        end else begin
            want = exp_q.pop_front();
            if (got != want) begin
                n_bad++;
                $display("[TB] FAIL event: got kind=%0d step=%0d tom=%0d notas=%0d start=%0d width=%0d, expected kind=%0d step=%0d tom=%0d notas=%0d start=%0d width=%0d",
                         got.kind, got.step, got.tom, got.notas, got.start, got.width,
                         want.kind, want.step, want.tom, want.notas, want.start, want.width);
            end
        end
    endtask

    function automatic rec_t mk(input int kind, input int step, input int tom, input int notas,
                                input int start, input int width);
        rec_t r;
        r.kind  = kind;
        r.step  = step;
        r.tom   = tom;
        r.notas = notas;
        r.start = start;
        r.width = width;
        return r;
    endfunction

    // Reference model: walks the score step by step with plain arithmetic.
    // Offsets count cycles from the first busy cycle. stop_at is the offset
    // of the cycle whose closing edge sees stop (or the reset that follows).
    task automatic model(input int len, input bit lp, input int flip, input int stop_at, input bit is_reset);
        int t;
        int s;
        int w;
        int p;
        bit lv;
        logic [6:0] e;
        t = 0;
        s = 0;
        for (int guard = 0; guard < 400; guard++) begin
            e = score[s];
            w = (int'(e[1:0]) + 1) * TPB;
            p = 1 + w + GAP;
            if (stop_at >= 0 && stop_at <= t + p - 1) begin
                if (!e[6] && stop_at >= t + 1) begin
                    exp_q.push_back(mk(K_NOTE, s, e[5], e[4:2], t + 1,
                                       ((stop_at < t + w) ? stop_at : t + w) - t));
                end
                exp_q.push_back(mk(K_ABORT, is_reset ? 0 : s, 0, 0, stop_at + 1, 0));
                return;
            end
            if (!e[6]) begin
                exp_q.push_back(mk(K_NOTE, s, e[5], e[4:2], t + 1, w));
            end
            lv = (flip >= 0 && t + p - 1 >= flip) ? !lp : lp;
            if (s < len) begin
                s++;
            end else if (lv) begin
                s = 0;
            end else begin
                exp_q.push_back(mk(K_DONE, s, 0, 0, t + p, 0));
                return;
            end
            t += p;
        end
    endtask

    // Monitor: rebuilds events from the DUT outputs at every falling edge.
    initial begin : monitor
        int  off;
        bit  prev_busy;
        bit  prev_note;
        rec_t run;
        off       = 0;
        prev_busy = 1'b0;
        prev_note = 1'b0;
        run       = mk(K_NOTE, 0, 0, 0, 0, 0);
        forever begin
            @(negedge clock);
            if (bus.busy && !prev_busy) off = 0;
            else off = off + 1;
            if (bus.note_on && !prev_note) begin
                run = mk(K_NOTE, bus.step, bus.tom, bus.notas, off, 1);
            end else if (bus.note_on) begin
                run.width++;
            end else if (prev_note) begin
                emit(run);
            end
            if (!bus.busy && prev_busy) begin
                emit(mk(bus.done ? K_DONE : K_ABORT, bus.step, 0, 0, off, 0));
            end else if (bus.done) begin
                checkOutput("done_outside_end", bus.done, 1'b0);
            end
            prev_busy = bus.busy;
            prev_note = bus.note_on;
        end
    end

    task automatic writeEntry(input int addr, input logic [6:0] data);
        @(negedge clock);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(addr);
        bus.wr_data = data;
        score[addr] = data;
        @(negedge clock);
        bus.wr_en   = 1'b0;
    endtask

    function automatic logic [6:0] ent(input bit rest, input bit tom, input int notas, input int dur);
        return {rest, tom, 3'(notas), 2'(dur)};
    endfunction

    task automatic checkReset(input string tag);
        checkOutput({tag, "_tom"},     bus.tom,     0);
        checkOutput({tag, "_notas"},   bus.notas,   0);
        checkOutput({tag, "_note_on"}, bus.note_on, 0);
        checkOutput({tag, "_step"},    bus.step,    0);
        checkOutput({tag, "_busy"},    bus.busy,    0);
        checkOutput({tag, "_done"},    bus.done,    0);
    endtask

    // Start one playback and drive loop changes, stray play, stop or reset
    // at given cycle offsets, then wait (bounded) for all events to arrive.
    task automatic applyStimulus(input int len, input bit lp, input int flip, input int stop_at,
                                 input bit do_reset, input int busy_play_at);
        bit finished;
        finished = 1'b0;
        @(negedge clock);
        bus.play = 1'b1;
        bus.stop = 1'b0;
        bus.len  = AW'(len);
        bus.loop = lp;
        model(len, lp, flip, stop_at, do_reset);
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            bus.play = (c == busy_play_at);
            if (c == flip) bus.loop = !lp;
            bus.stop = (c == stop_at) && !do_reset;
            if (do_reset && c == stop_at) begin
                @(posedge clock);
                #2 reset_n = 1'b0;
                #1 checkReset("async_reset");
            end
            #1;
            if (!bus.busy && exp_q.size() == 0) begin
                finished = 1'b1;
                break;
            end
        end
        bus.play = 1'b0;
        bus.stop = 1'b0;
        bus.loop = 1'b0;
        if (!finished) begin
            checkOutput("timeout_pending_events", exp_q.size(), 0);
            exp_q.delete();
        end
        if (do_reset) begin
            @(negedge clock);
            reset_n = 1'b1;
        end
        repeat (2) @(negedge clock);
    endtask

    initial begin : driver
        int p0;
        int p1;
        int len;
        reset_n     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.len     = '0;
        bus.loop    = 1'b0;
        bus.play    = 1'b0;
        bus.stop    = 1'b0;
        repeat (3) @(negedge clock);
        checkReset("reset");
        reset_n = 1'b1;
        @(negedge clock);

        // Single step.
        writeEntry(0, ent(0, 1, 5, 0));
        applyStimulus(0, 0, -1, -1, 0, -1);

        // Three steps with growing durations; a stray play while busy.
        writeEntry(0, ent(0, 0, 1, 0));
        writeEntry(1, ent(0, 1, 2, 1));
        writeEntry(2, ent(0, 0, 3, 3));
        applyStimulus(2, 0, -1, -1, 0, 3);

        // Rest in the middle.
        writeEntry(1, ent(1, 1, 6, 0));
        applyStimulus(2, 0, -1, -1, 0, -1);

        // Loop, dropped during the second pass.
        writeEntry(0, ent(0, 1, 4, 1));
        writeEntry(1, ent(0, 0, 7, 0));
        p0 = 1 + 2 * TPB + GAP;
        p1 = 1 + TPB + GAP;
        applyStimulus(1, 1, p0 + p1 + 1, -1, 0, -1);

        // Stop during PLAY of step 1.
        writeEntry(1, ent(0, 1, 2, 2));
        applyStimulus(2, 0, -1, p0 + 3, 0, -1);

        // play and stop together in IDLE.
        @(negedge clock);
        bus.play = 1'b1;
        bus.stop = 1'b1;
        @(negedge clock);
        bus.play = 1'b0;
        bus.stop = 1'b0;
        checkOutput("play_stop_busy", bus.busy, 0);
        @(negedge clock);
        checkOutput("play_stop_busy_later", bus.busy, 0);

        // Asynchronous reset mid-PLAY, then replay from intact RAM.
        applyStimulus(2, 0, -1, 3, 1, -1);
        applyStimulus(2, 0, -1, -1, 0, -1);

        // Random scores, some looping, some stopped.
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < NS; a++) begin
                writeEntry(a, 7'($urandom));
            end
            len = $urandom_range(NS - 1, 0);
            if (r % 3 == 1) applyStimulus(len, 1, $urandom_range(120, 10), -1, 0, -1);
            else if (r % 3 == 2) applyStimulus(len, 0, -1, $urandom_range(60, 0), 0, 2);
            else applyStimulus(len, 0, -1, -1, 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
